// File: rtl/cpu_mem_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cpu_mem_arbiter
//
// Merges the CPU's instruction-fetch and data load/store SRAM-like ports onto
// one shared single-port memory bus. Only one transaction is in flight at a
// time. A request is accepted (addr_ok) combinationally in IDLE. The command is
// then registered onto the bus and held until mem_gnt. The response on
// mem_rvalid is captured into the owning port's rdata register. That port's
// data_ok pulses for one cycle afterwards.
//
// Parameters:
//   KSEG_MAP  1: kseg0/kseg1 (addr[31:29] = 3'b100 / 3'b101) map to physical by
//                clearing addr[31:29]. 0: addresses pass through unchanged.
//
// Build option:
//   ARB_ROUND_ROBIN_EN  when defined, simultaneous requests alternate between
//                       the two ports. When undefined, data always wins over
//                       inst.
//
// Ports:
//   clk, resetn                          clock, async active-low reset
//   inst_req/addr -> inst_addr_ok, inst_data_ok, inst_rdata
//   data_req/wr/wstrb/addr/wdata -> data_addr_ok, data_data_ok, data_rdata
//   mem_req/wr/wstrb/addr/wdata          registered bus command, held until gnt
//   mem_gnt, mem_rvalid, mem_rdata       bus accept / response
// -----------------------------------------------------------------------------
module cpu_mem_arbiter #(
  parameter bit KSEG_MAP = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  // instruction port
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data port
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // shared memory bus
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  state_t state;
  owner_t owner;

`ifdef ARB_ROUND_ROBIN_EN
  owner_t last_grant;
`endif

  logic grant_any;
  logic grant_data;

  // kseg0/kseg1 -> physical: both windows alias the low 512 MB.
  function automatic logic [31:0] map_addr(input logic [31:0] a);
    if (KSEG_MAP && (a[31:29] == 3'b100 || a[31:29] == 3'b101))
      return {3'b000, a[28:0]};
    else
      return a;
  endfunction

  // Arbitration: which port wins if a grant happens this cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    grant_data = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    if (data_req && inst_req)
      grant_data = (last_grant == OWN_INST);
    else
      grant_data = data_req;
`else
    grant_data = data_req;
`endif
  end

  // addr_ok is combinational so the CPU sees acceptance in its request cycle.
  // It is gated with resetn so it reads 0 during reset as well.
  assign grant_any    = resetn && (state == S_IDLE) && (inst_req || data_req);
  assign data_addr_ok = grant_any &&  grant_data;
  assign inst_addr_ok = grant_any && !grant_data;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      owner        <= OWN_INST;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant   <= OWN_INST;
`endif
      mem_req      <= 1'b0;
      mem_wr       <= 1'b0;
      mem_wstrb    <= 4'b0000;
      mem_addr     <= 32'h0;
      mem_wdata    <= 32'h0;
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
      inst_rdata   <= 32'h0;
      data_rdata   <= 32'h0;
    end else begin
      // data_ok is a single-cycle pulse: only the WAIT->RESP edge sets it.
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;

      case (state)
        S_IDLE: begin
          if (grant_any) begin
            mem_req <= 1'b1;
            state   <= S_REQ;
            if (grant_data) begin
              owner     <= OWN_DATA;
              mem_wr    <= data_wr;
              mem_wstrb <= data_wstrb;
              mem_addr  <= map_addr(data_addr);
              mem_wdata <= data_wdata;
            end else begin
              owner     <= OWN_INST;
              mem_wr    <= 1'b0;
              mem_wstrb <= 4'b0000;
              mem_addr  <= map_addr(inst_addr);
              mem_wdata <= 32'h0;
            end
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= grant_data ? OWN_DATA : OWN_INST;
`endif
          end
        end

        S_REQ: begin
          // Command fields stay frozen until the bus takes them.
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= S_WAIT;
          end
        end

        S_WAIT: begin
          // mem_rvalid is only meaningful here; elsewhere it is ignored.
          if (mem_rvalid) begin
            if (owner == OWN_DATA) begin
              data_rdata   <= mem_rdata;
              data_data_ok <= 1'b1;
            end else begin
              inst_rdata   <= mem_rdata;
              inst_data_ok <= 1'b1;
            end
            state <= S_RESP;
          end
        end

        S_RESP: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_cpu_mem_arbiter
//
// Directed bench for cpu_mem_arbiter. Stimulus tasks push the expected bus
// command, the bus response data and the expected CPU-side response into
// queues. A bus responder consumes commands with programmable gnt/rvalid
// delays. A monitor pops expected responses whenever a data_ok pulse appears.
// A second instance with KSEG_MAP=0 shares all inputs to cover pass-through.
// -----------------------------------------------------------------------------
module tb_cpu_mem_arbiter;

  typedef struct packed {
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic        port;   // 1 = data, 0 = inst
    logic [31:0] rdata;
  } resp_t;

  logic        clk;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  // outputs of the pass-through (KSEG_MAP=0) instance
  logic        raw_inst_addr_ok, raw_inst_data_ok, raw_data_addr_ok, raw_data_data_ok;
  logic [31:0] raw_inst_rdata, raw_data_rdata;
  logic        raw_mem_req, raw_mem_wr;
  logic [3:0]  raw_mem_wstrb;
  logic [31:0] raw_mem_addr, raw_mem_wdata;

  cpu_mem_arbiter #(.KSEG_MAP(1'b1)) u_dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  cpu_mem_arbiter #(.KSEG_MAP(1'b0)) u_raw (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(raw_inst_addr_ok), .inst_data_ok(raw_inst_data_ok), .inst_rdata(raw_inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(raw_data_addr_ok), .data_data_ok(raw_data_data_ok), .data_rdata(raw_data_rdata),
    .mem_req(raw_mem_req), .mem_wr(raw_mem_wr), .mem_wstrb(raw_mem_wstrb),
    .mem_addr(raw_mem_addr), .mem_wdata(raw_mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cmd_t        cmd_q[$];
  logic [31:0] bus_q[$];
  resp_t       sb_q[$];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          gnt_delay = 0;
  int          rv_delay = 1;
  bit          manual_bus = 1'b0;
  bit          raw_chk = 1'b0;
  logic [31:0] raw_exp = 32'h0;
  logic [31:0] mdl_inst_rd = 32'h0;
  logic [31:0] mdl_data_rd = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Checks the bus command against the expected one while mem_req is up.
  task automatic chk_cmd(input cmd_t c);
    check("mem_req_held", mem_req, 1);
    check("mem_wr", mem_wr, c.wr);
    check("mem_wstrb", mem_wstrb, c.wstrb);
    check("mem_addr", mem_addr, c.addr);
    if (c.wr) check("mem_wdata", mem_wdata, c.wdata);
    if (raw_chk) check("raw_mem_addr", raw_mem_addr, raw_exp);
  endtask

  // Bus slave: gnt after gnt_delay cycles, rvalid rv_delay cycles after gnt.
  task automatic responder();
    cmd_t c;
    forever begin
      @(posedge clk); #1;
      if (mem_req && !manual_bus) begin
        if (cmd_q.size() == 0) begin
          fail_now("unexpected_mem_req");
          c = '0;
        end else begin
          c = cmd_q.pop_front();
        end
        for (int i = 0; i < gnt_delay; i++) begin
          chk_cmd(c);
          @(posedge clk); #1;
        end
        chk_cmd(c);
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        for (int i = 1; i < rv_delay; i++) begin
          @(posedge clk); #1;
        end
        mem_rvalid = 1'b1;
        mem_rdata  = (bus_q.size() != 0) ? bus_q.pop_front() : 32'h0;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
      end
    end
  endtask

  // Pops one expected response per observed data_ok pulse.
  task automatic monitor();
    resp_t e;
    forever begin
      @(negedge clk);
      if (inst_data_ok || data_data_ok) begin
        if (inst_data_ok && data_data_ok) fail_now("both_data_ok");
        if (sb_q.size() == 0) begin
          fail_now("unexpected_data_ok");
        end else begin
          e = sb_q.pop_front();
          check("resp_port", data_data_ok, e.port);
          check("resp_rdata", e.port ? data_rdata : inst_rdata, e.rdata);
        end
      end
    end
  endtask

  // Issues one transaction; lat = cycles from addr_ok to data_ok.
  task automatic issue(input bit is_data, input bit wr, input logic [3:0] wstrb,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_addr, input logic [31:0] rdata,
                       output int lat);
    int t;
    cmd_q.push_back('{wr: is_data & wr, wstrb: is_data ? wstrb : 4'b0000,
                      addr: exp_addr, wdata: wdata});
    bus_q.push_back(rdata);
    sb_q.push_back('{port: is_data, rdata: rdata});
    if (is_data) mdl_data_rd = rdata; else mdl_inst_rd = rdata;
    @(posedge clk); #1;
    if (is_data) begin
      data_req = 1'b1; data_wr = wr; data_wstrb = wstrb;
      data_addr = addr; data_wdata = wdata;
    end else begin
      inst_req = 1'b1; inst_addr = addr;
    end
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(is_data ? data_addr_ok : inst_addr_ok) && t < 50);
    if (t >= 50) fail_now("accept_timeout");
    @(posedge clk); #1;
    data_req = 1'b0;
    inst_req = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(is_data ? data_data_ok : inst_data_ok) && lat < 100);
    if (lat >= 100) fail_now("data_ok_timeout");
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain_remaining", sb_q.size(), 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    mdl_inst_rd = 32'h0;
    mdl_data_rd = 32'h0;
  endtask

  initial begin
    int   lat;
    int   g, cyc, last;
    bit   exp_order[3];

    resetn = 1'b0;
    inst_req = 1'b0; inst_addr = 32'h0;
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0;
    data_addr = 32'h0; data_wdata = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

    fork
      monitor();
      responder();
    join_none

    // Reset state
    #3;
    check("rst_mem_req", mem_req, 0);
    check("rst_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
    check("rst_data_ok", {inst_data_ok, data_data_ok}, 0);
    check("rst_inst_rdata", inst_rdata, 0);
    check("rst_data_rdata", data_rdata, 0);
    check("rst_mem_addr", mem_addr, 0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Single inst read from kseg1, zero-wait bus
    gnt_delay = 0; rv_delay = 1;
    issue(1'b0, 1'b0, 4'h0, 32'hBFC0_0000, 32'h0, 32'h1FC0_0000, 32'h3C08_0001, lat);
    check("inst_latency", lat, 3);
    check("inst_rdata_hold", inst_rdata, 32'h3C08_0001);

    // Data write in kseg0 with gnt delayed 3 cycles
    gnt_delay = 3;
    issue(1'b1, 1'b1, 4'b0011, 32'h8000_1000, 32'hDEAD_BEEF, 32'h0000_1000, 32'h5A5A_0001, lat);
    check("write_latency", lat, 6);
    gnt_delay = 0;

    // Write with all byte enables off is still issued and acknowledged
    issue(1'b1, 1'b1, 4'b0000, 32'h0000_2000, 32'h0102_0304, 32'h0000_2000, 32'h5A5A_0002, lat);
    check("zero_wstrb_latency", lat, 3);

    // Pass-through: KSEG_MAP=0 instance keeps kseg1 address, mapped one strips it
    raw_chk = 1'b1; raw_exp = 32'hA000_0010;
    issue(1'b1, 1'b0, 4'h0, 32'hA000_0010, 32'h0, 32'h0000_0010, 32'h1111_2222, lat);
    raw_chk = 1'b0;
    drain();

    // Spurious rvalid in IDLE, then a read with rvalid 5 cycles after gnt
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    @(negedge clk);
    check("spurious_inst_rdata", inst_rdata, mdl_inst_rd);
    check("spurious_data_rdata", data_rdata, mdl_data_rd);
    rv_delay = 5;
    issue(1'b1, 1'b0, 4'h0, 32'hC000_0040, 32'h0, 32'hC000_0040, 32'hCAFE_F00D, lat);
    check("slow_read_latency", lat, 7);
    rv_delay = 1;
    drain();

    // Simultaneous requests for 3 grants, starting from reset pointer state
    pulse_reset();
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{1'b1, 1'b0, 1'b1};
`else
    exp_order = '{1'b1, 1'b1, 1'b1};
`endif
    for (int k = 0; k < 3; k++) begin
      if (exp_order[k]) begin
        cmd_q.push_back('{wr: 1'b0, wstrb: 4'h0, addr: 32'h0000_2000, wdata: 32'h0});
        mdl_data_rd = 32'h1000_0000 + k;
      end else begin
        cmd_q.push_back('{wr: 1'b0, wstrb: 4'h0, addr: 32'h0040_0100, wdata: 32'h0});
        mdl_inst_rd = 32'h1000_0000 + k;
      end
      bus_q.push_back(32'h1000_0000 + k);
      sb_q.push_back('{port: exp_order[k], rdata: 32'h1000_0000 + k});
    end
    @(posedge clk); #1;
    inst_req = 1'b1; inst_addr = 32'h0040_0100;
    data_req = 1'b1; data_wr = 1'b0; data_wstrb = 4'h0;
    data_addr = 32'h8000_2000; data_wdata = 32'h0;
    g = 0; cyc = 0; last = 0;
    while (g < 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (inst_addr_ok || data_addr_ok) begin
        check("grant_port", data_addr_ok, exp_order[g]);
        if (g > 0) check("grant_spacing", cyc - last, 4);
        last = cyc;
        g++;
        if (g == 3) begin
          @(posedge clk); #1;
          inst_req = 1'b0;
          data_req = 1'b0;
        end
      end
    end
    if (g < 3) fail_now("simultaneous_grant_timeout");
    drain();
    check("both_inst_rdata", inst_rdata, mdl_inst_rd);
    check("both_data_rdata", data_rdata, mdl_data_rd);

    // Reset during WAIT: everything clears immediately, late rvalid dropped
    manual_bus = 1'b1;
    @(posedge clk); #1;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h8000_0010;
    @(negedge clk);
    check("rst_test_accept", data_addr_ok, 1);
    @(posedge clk); #1;
    data_req = 1'b0;
    check("rst_test_mem_req", mem_req, 1);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h0000_0400;
    #2;
    resetn = 1'b0;
    #1;
    check("midrst_mem_req", mem_req, 0);
    check("midrst_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
    check("midrst_data_ok", {inst_data_ok, data_data_ok}, 0);
    check("midrst_data_rdata", data_rdata, 0);
    check("midrst_inst_rdata", inst_rdata, 0);
    check("midrst_mem_addr", mem_addr, 0);
    check("midrst_mem_fields", {mem_wr, mem_wstrb}, 0);
    mdl_inst_rd = 32'h0;
    mdl_data_rd = 32'h0;
    inst_req = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    @(negedge clk);
    check("late_rvalid_data_rdata", data_rdata, 0);
    check("late_rvalid_mem_req", mem_req, 0);
    manual_bus = 1'b0;
    issue(1'b0, 1'b0, 4'h0, 32'hBFC0_0004, 32'h0, 32'h1FC0_0004, 32'h2402_0005, lat);
    check("post_rst_latency", lat, 3);
    drain();

    repeat (3) @(posedge clk);
    disable fork;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_mem_arbiter.md
# cpu_mem_arbiter

Arbitrates the CPU core's two sram-like memory ports (instruction fetch, data load/store) onto one shared single-port memory bus with a request/grant/response handshake. It sits directly downstream of the CPU top-level's inst/data SRAM ports and replaces their fixed-latency connection with a variable-latency one. One transaction is in flight at a time. Optionally translates kseg0/kseg1 virtual addresses to physical.

## Interface
Parameters:
- KSEG_MAP, default 1: 1 = apply kseg0/kseg1 address translation; 0 = addresses pass unchanged.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- inst_req  in  1  instruction read request.
- inst_addr  in  32  instruction byte address.
- inst_addr_ok  out  1  inst request accepted this cycle.
- inst_data_ok  out  1  one-cycle pulse: inst_rdata valid.
- inst_rdata  out  32  fetched instruction.
- data_req  in  1  data request.
- data_wr  in  1  1 = write, 0 = read.
- data_wstrb  in  4  byte enables for writes.
- data_addr  in  32  data byte address.
- data_wdata  in  32  write data.
- data_addr_ok  out  1  data request accepted this cycle.
- data_data_ok  out  1  one-cycle pulse: read data valid / write complete.
- data_rdata  out  32  load data.
- mem_req  out  1  bus request, held until mem_gnt.
- mem_wr, mem_wstrb[3:0], mem_addr[31:0], mem_wdata[31:0]  out  bus command fields, stable while mem_req=1.
- mem_gnt  in  1  bus accepted command this cycle.
- mem_rvalid  in  1  response (read data or write ack); at least one cycle after mem_gnt.
- mem_rdata  in  32  read data, valid with mem_rvalid.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: if any request pending, grant one, assert its *_addr_ok combinationally this cycle, latch wr/wstrb/addr/wdata and owner; -> REQ. Inst requests latch wr=0, wstrb=0.
- REQ: mem_req=1 with latched fields; on mem_gnt -> WAIT.
- WAIT: on mem_rvalid capture mem_rdata into owner's rdata register -> RESP.
- RESP: owner's *_data_ok=1 for exactly this cycle -> IDLE. Requests are not accepted in REQ/WAIT/RESP (addr_ok=0).
- Priority (default): data over inst on simultaneous requests; inst may starve under continuous data traffic.
- Address map (KSEG_MAP=1): addr[31:29] of 3'b100 or 3'b101 -> mem_addr = {3'b000, addr[28:0]}; all other addresses unchanged.
- Writes with data_wstrb=4'b0000 are still issued and acknowledged.
- inst_rdata/data_rdata hold last captured value until next capture for that port.
- mem_rvalid outside WAIT is ignored.

## Timing
- Reset: state IDLE; all outputs 0 (mem_req, *_addr_ok, *_data_ok, rdata regs, latched fields, round-robin pointer = inst last).
- Min latency, zero-wait bus: addr_ok cycle 0, mem_req cycle 1, mem_gnt cycle 1, mem_rvalid cycle 2, data_ok cycle 3; next request acceptable cycle 4.
- Throughput: one transaction per 4 cycles minimum.
- mem_req and command fields are registered; never change while mem_req=1 and mem_gnt=0.
- Reset asserted mid-transaction: immediately IDLE, outputs 0, in-flight response dropped; bus side is reset on the same resetn.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on simultaneous inst_req and data_req, grant goes to the port not granted last; pointer updates on every grant. Single requests granted immediately regardless of pointer.
- Not defined: fixed data-over-inst priority; pointer logic absent.

## Test plan
- Single inst read at 0xBFC00000, KSEG_MAP=1, zero-wait bus returning 0x3C080001 -> mem_addr=0x1FC00000, mem_wr=0, inst_data_ok pulses cycle 3, inst_rdata=0x3C080001.
- Data write addr 0x80001000, wstrb 4'b0011, wdata 0xDEADBEEF, mem_gnt delayed 3 cycles -> fields stable while waiting, mem_addr=0x00001000, data_data_ok one pulse after mem_rvalid.
- inst_req and data_req both high for 3 transactions -> default: data, data, data; ARB_ROUND_ROBIN_EN: data, inst, data.
- Spurious mem_rvalid in IDLE, then read with rvalid 5 cycles after gnt -> no data_ok from spurious pulse; correct rdata captured.
- resetn low during WAIT -> all outputs 0 immediately; later mem_rvalid ignored; new inst_req after release accepted normally.
- KSEG_MAP=0, addr 0xA0000010 -> mem_addr=0xA0000010.
